// File: rtl/timer_multi_if.sv
// rtl/timer_multi_if.sv - Wishbone register bus bundle for timer_multi
interface timer_multi_if;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic        ack;
    logic        err;

    modport master (
        output adr, dat_ms, sel, we, cyc, stb,
        input  dat_sm, ack, err
    );

    modport slave (
        input  adr, dat_ms, sel, we, cyc, stb,
        output dat_sm, ack, err
    );
endinterface

// File: rtl/timer_multi.sv
// rtl/timer_multi.sv - N_CH prescaled compare timers, W1C status, per-channel IRQ; TIMER_CASCADE_EN adds CFG[8] cascade
module timer_multi #(
    parameter int N_CH   = 4,
    parameter int CNT_W  = 32,
    parameter int PRSC_W = 4
) (
    input  logic            clk,
    input  logic            rst_i,
    output logic [N_CH-1:0] irq_o,
    timer_multi_if.slave    wb_bus
);

`ifdef TIMER_CASCADE_EN
    localparam bit CASCADE_IMPL = 1'b1;
`else
    localparam bit CASCADE_IMPL = 1'b0;
`endif

    // Prescaler counter must reach 2^PRSC-1 for the largest PRSC.
    localparam int          PC_W       = (1 << PRSC_W) - 1;
    localparam logic [31:0] STATUS_ADR = 32'(N_CH * 16);

    logic [31:0]      cfg_q   [N_CH];
    logic [CNT_W-1:0] count_q [N_CH];
    logic [CNT_W-1:0] cmp_q   [N_CH];
    logic [PC_W-1:0]  pc_q    [N_CH];
    logic [N_CH-1:0]  status_q;

    logic            req, req_ok, req_wr, wr_status;
    logic [31:0]     lane_mask, rd_data;
    logic [N_CH-1:0] wr_cfg, wr_count, wr_cmp;
    logic [N_CH-1:0] pc_hit, tick, match, w1c;

    function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [31:0] m);
        return (old_v & ~m) | (new_v & m);
    endfunction

    // Writable CFG bits; the cascade bit exists only above channel 0.
    function automatic logic [31:0] cfg_wmask(input int ch);
        logic [31:0] m;
        m = 32'h0000_0007;
        for (int b = 4; b < PRSC_W + 4; b++) m[b] = 1'b1;
        m[8] = CASCADE_IMPL && (ch > 0);
        return m;
    endfunction

    function automatic logic [PC_W-1:0] pc_limit(input logic [PRSC_W-1:0] p);
        logic [PC_W:0] one_hot;
        one_hot    = '0;
        one_hot[p] = 1'b1;
        return PC_W'(one_hot - (PC_W + 1)'(1));
    endfunction

    // Bus decode, read mux, tick/match chain and interrupt outputs.
    always_comb begin
        logic carry;
        logic hit;
        carry     = 1'b0;
        hit       = 1'b0;
        req       = wb_bus.cyc & wb_bus.stb & ~(wb_bus.ack | wb_bus.err);
        req_ok    = req & (wb_bus.adr <= STATUS_ADR);
        req_wr    = req_ok & wb_bus.we;
        lane_mask = {{8{wb_bus.sel[3]}}, {8{wb_bus.sel[2]}},
                     {8{wb_bus.sel[1]}}, {8{wb_bus.sel[0]}}};
        wr_status = req_wr & (wb_bus.adr[31:4] == 28'(N_CH));
        w1c       = wr_status ? (wb_bus.dat_ms[N_CH-1:0] & lane_mask[N_CH-1:0]) : '0;
        rd_data   = '0;
        if (wb_bus.adr[31:4] == 28'(N_CH)) rd_data = 32'(status_q);
        for (int i = 0; i < N_CH; i++) begin
            hit         = (wb_bus.adr[31:4] == 28'(i));
            wr_cfg[i]   = req_wr & hit & (wb_bus.adr[3:2] == 2'd0);
            wr_count[i] = req_wr & hit & (wb_bus.adr[3:2] == 2'd1);
            wr_cmp[i]   = req_wr & hit & (wb_bus.adr[3:2] == 2'd2);
            if (hit) begin
                case (wb_bus.adr[3:2])
                    2'd0:    rd_data = cfg_q[i];
                    2'd1:    rd_data = 32'(count_q[i]);
                    2'd2:    rd_data = 32'(cmp_q[i]);
                    default: rd_data = '0;
                endcase
            end
            pc_hit[i] = (pc_q[i] == pc_limit(cfg_q[i][PRSC_W+3:4]));
            // A cascaded channel counts matches of its lower neighbour instead of prescaler ticks.
            if (cfg_q[i][8]) tick[i] = cfg_q[i][0] & carry;
            else             tick[i] = cfg_q[i][0] & pc_hit[i];
            match[i] = tick[i] & (count_q[i] == cmp_q[i]);
            carry    = match[i];
            irq_o[i] = status_q[i] & cfg_q[i][2];
        end
    end

    // Bus response, register writes and per-channel counting; software writes beat hardware updates.
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_CH; i++) begin
                cfg_q[i]   <= '0;
                count_q[i] <= '0;
                cmp_q[i]   <= '0;
                pc_q[i]    <= '0;
            end
            status_q      <= '0;
            wb_bus.ack    <= 1'b0;
            wb_bus.err    <= 1'b0;
            wb_bus.dat_sm <= '0;
        end else begin
            wb_bus.ack    <= req_ok;
            wb_bus.err    <= req & ~req_ok;
            wb_bus.dat_sm <= (req_ok & ~wb_bus.we) ? rd_data : '0;
            // Hardware set wins over a same-cycle clear.
            status_q      <= (status_q & ~w1c) | match;
            for (int i = 0; i < N_CH; i++) begin
                if (wr_cfg[i] || !cfg_q[i][0] || pc_hit[i]) pc_q[i] <= '0;
                else                                        pc_q[i] <= pc_q[i] + PC_W'(1);

                if (wr_cfg[i])
                    cfg_q[i] <= merge_lanes(cfg_q[i], wb_bus.dat_ms, lane_mask) & cfg_wmask(i);
                else if (match[i] && cfg_q[i][1])
                    cfg_q[i][0] <= 1'b0;

                if (wr_count[i])
                    count_q[i] <= CNT_W'(merge_lanes(32'(count_q[i]), wb_bus.dat_ms, lane_mask));
                else if (match[i])
                    count_q[i] <= '0;
                else if (tick[i])
                    count_q[i] <= count_q[i] + CNT_W'(1);

                if (wr_cmp[i])
                    cmp_q[i] <= CNT_W'(merge_lanes(32'(cmp_q[i]), wb_bus.dat_ms, lane_mask));
            end
        end
    end

endmodule

// File: tb/tb_timer_multi.sv
// tb/tb_timer_multi.sv - directed self-checking bench for timer_multi
module tb_timer_multi;
    localparam int N_CH   = 4;
    localparam int CNT_W  = 16;
    localparam int PRSC_W = 4;
    localparam logic [31:0] STA = 32'h40;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic [N_CH-1:0] irq_o;

    timer_multi_if wb();

    timer_multi #(.N_CH(N_CH), .CNT_W(CNT_W), .PRSC_W(PRSC_W)) dut (
        .clk    (clk),
        .rst_i  (rst_i),
        .irq_o  (irq_o),
        .wb_bus (wb)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] r_dat;
    logic        r_ack, r_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // One request edge followed by one idle edge so the next request is not masked by ack/err.
    task automatic bus(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        wb.adr = a; wb.we = w; wb.dat_ms = d; wb.sel = s; wb.cyc = 1'b1; wb.stb = 1'b1;
        @(posedge clk); #1;
        r_dat = wb.dat_sm; r_ack = wb.ack; r_err = wb.err;
        wb.cyc = 1'b0; wb.stb = 1'b0; wb.we = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(a, 1'b1, d, 4'hF);
    endtask

    task automatic rd(input logic [31:0] a);
        bus(a, 1'b0, 32'h0, 4'hF);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        wb.adr = '0; wb.dat_ms = '0; wb.sel = '0; wb.we = 1'b0; wb.cyc = 1'b0; wb.stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_ack", 32'(wb.ack), 32'h0);
        check("rst_err", 32'(wb.err), 32'h0);
        check("rst_dat", wb.dat_sm, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;

        // Periodic ch0: CMP=3, PRSC=0; EN write at E0, reads at E2,E7,E12,E17,E22 see COUNT after the previous edge.
        wr(32'h08, 32'h3);
        wr(32'h00, 32'h5);
        begin
            logic [31:0] exp_cnt [5];
            exp_cnt = '{32'h1, 32'h2, 32'h3, 32'h0, 32'h1};
            for (int j = 0; j < 5; j++) begin
                rd(32'h04);
                check($sformatf("per_count%0d", j), r_dat, exp_cnt[j]);
                if (j < 4) idle(3);
            end
        end
        rd(STA);
        check("per_status", r_dat, 32'h1);
        check("per_irq_hi", 32'(irq_o), 32'h1);
        wr(STA, 32'h1);                       // E26, not a match edge
        check("per_irq_w1c", 32'(irq_o), 32'h0);
        idle(4);
        wr(STA, 32'h1);                       // E32, ch0 matches here
        check("coll_irq", 32'(irq_o), 32'h1);
        rd(STA);
        check("coll_status", r_dat, 32'h1);

        // COUNT write on a prescaled tick edge (PRSC=2, tick 4 edges after the CFG write).
        wr(32'h00, 32'h25);
        idle(2);
        wr(32'h04, 32'h10);
        rd(32'h04);
        check("coll_count", r_dat, 32'h10);
        idle(2);
        wr(32'h00, 32'h0);                    // disable after one more tick -> 0x11
        idle(5);
        rd(32'h04);
        check("freeze_count", r_dat, 32'h11);
        rd(STA);
        check("freeze_status", r_dat, 32'h1);
        wr(STA, 32'hF);
        rd(STA);
        check("clr_status", r_dat, 32'h0);

        // One-shot ch1: CMP=2, PRSC=2 -> match 12 edges after the EN write.
        wr(32'h18, 32'h2);
        wr(32'h10, 32'h27);
        repeat (10) @(posedge clk);
        #1;
        check("os_irq_early", 32'(irq_o), 32'h0);
        @(posedge clk); #1;
        check("os_irq_match", 32'(irq_o), 32'h2);
        rd(32'h10);
        check("os_cfg_en0", r_dat, 32'h26);
        rd(32'h14);
        check("os_count", r_dat, 32'h0);
        idle(20);
        rd(32'h14);
        check("os_count_hold", r_dat, 32'h0);
        rd(STA);
        check("os_status", r_dat, 32'h2);
        wr(STA, 32'h2);

        // Bus behaviour.
        rd(STA + 32'h4);
        check("bad_err", 32'(r_err), 32'h1);
        check("bad_ack", 32'(r_ack), 32'h0);
        check("bad_dat", r_dat, 32'h0);
        check("bad_err_1cyc", 32'(wb.err), 32'h0);
        rd(STA);
        check("sta_ack", 32'(r_ack), 32'h1);
        wr(32'h28, 32'h1234);
        bus(32'h28, 1'b1, 32'hFFFF_FFAB, 4'b0001);
        rd(32'h28);
        check("sel_lane0", r_dat, 32'h12AB);
        bus(32'h28, 1'b1, 32'h0000_CD00, 4'b0010);
        rd(32'h28);
        check("sel_lane1", r_dat, 32'hCDAB);
        wr(32'h38, 32'hFFFF_FFFF);
        rd(32'h38);
        check("cmp_width", r_dat, 32'h0000_FFFF);
        wr(32'h0C, 32'hFFFF_FFFF);
        rd(32'h0C);
        check("reserved_raz", r_dat, 32'h0);
        wr(32'h00, 32'h100);
        rd(32'h00);
        check("cfg0_bit8", r_dat, 32'h0);
        wr(32'h10, 32'h100);
        rd(32'h10);
`ifdef TIMER_CASCADE_EN
        check("cfg1_bit8", r_dat, 32'h100);
        // Cascade: ch0 CMP=1 matches every 2 edges, ch1 CMP=2 counts those -> match 6 edges after ch0 EN.
        wr(32'h08, 32'h1);
        wr(32'h04, 32'h0);
        wr(32'h18, 32'h2);
        wr(32'h14, 32'h0);
        wr(32'h10, 32'h105);
        wr(32'h00, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        check("casc_irq_early", 32'(irq_o), 32'h0);
        @(posedge clk); #1;
        check("casc_irq_match", 32'(irq_o), 32'h2);
        wr(32'h00, 32'h0);
        wr(32'h10, 32'h0);
        wr(STA, 32'hF);
`else
        check("cfg1_bit8", r_dat, 32'h0);
`endif

        // Reset in the middle of counting with an ack on the bus.
        wr(32'h08, 32'h0);
        wr(32'h04, 32'h0);
        wr(32'h00, 32'h5);
        idle(3);
        #1;
        check("pre_rst_irq", 32'(irq_o), 32'h1);
        @(negedge clk);
        wb.adr = STA; wb.we = 1'b0; wb.sel = 4'hF; wb.cyc = 1'b1; wb.stb = 1'b1;
        @(posedge clk); #1;
        check("pre_rst_ack", 32'(wb.ack), 32'h1);
        #2 rst_i = 1'b1;
        #1;
        check("mid_rst_ack", 32'(wb.ack), 32'h0);
        check("mid_rst_irq", 32'(irq_o), 32'h0);
        check("mid_rst_dat", wb.dat_sm, 32'h0);
        wb.cyc = 1'b0; wb.stb = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ack_next", 32'(wb.ack), 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        rd(32'h00);
        check("rst_cfg0", r_dat, 32'h0);
        rd(32'h04);
        check("rst_count0", r_dat, 32'h0);
        rd(32'h08);
        check("rst_cmp0", r_dat, 32'h0);
        rd(STA);
        check("rst_status", r_dat, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
